conv_skew_feeder: RTL and testbench
===================================

# conv_skew_feeder

Streaming row-skew feeder for the systolic convolution array. It accepts one kernel-height column of fp16 input-map data per handshake and emits diagonally skewed row vectors: lane i is delayed by i beats and zero-filled outside the data span. Each vector is broadcast to SA_UNITS array units. It sits between the feature-map buffer and the convolution unit's DP_data/calculate inputs, and performs in hardware the skew that benches have so far built by hand. Row length is selectable at run time, and both sides use valid/ready flow control.

## Interface
- DATA_WIDTH, 16, element width (fp16 bit pattern, passed through untouched)
- KERNEL_SIZE, 3, number of kernel rows = skew lanes
- SA_UNITS, 4, number of array units receiving the broadcast vector
- MAX_LEN, 64, maximum input row length (columns per sweep)
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  begin a sweep; sampled only in IDLE
- cfg_len  in  LEN_W  row length for the sweep; latched on accepted start
- abort  in  1  synchronous sweep cancel
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  input column valid
- in_ready  out  1  feeder can accept a column
- in_col  in  [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  column c: in_col[i] = map[i][c]
- out_valid  out  1  skewed vector valid; also drives the array's calculate input
- out_ready  in  1  downstream accepts the vector
- out_last  out  1  final beat of the sweep
- out_data  out  [SA_UNITS-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  skewed vector, identical for every unit

## Operation
- The state machine has three states: IDLE, FILL and FLUSH.
- **IDLE**
  - On start with cfg_len != 0: latch len = min(cfg_len, MAX_LEN), clear all skew registers and counters, and go to FILL.
  - start with cfg_len == 0 is ignored; the block stays in IDLE.
- **Step condition:** step = (!out_valid || out_ready) && source_available.
  - In FILL, the source is the input handshake (in_valid && in_ready).
  - In FLUSH, zero columns are always available.
- **Skew datapath:** lane i holds an i-deep shift register that advances only on step.
  - Lane 0 takes the new column element directly.
  - Lane i emits the element entered i steps earlier, or 0 if none was entered.
- **Beat definition:** output beat j has lane i = map[i][j-i] when 0 <= j-i < len, else 0.
  - A sweep is exactly len + 2*(KERNEL_SIZE-1) beats.
  - The pad count is set by the Configuration section when the macro is defined.
- **FILL:** in_ready = (!out_valid || out_ready). After len accepted columns, go to FLUSH.
- **FLUSH:** inject zero columns for 2*(KERNEL_SIZE-1) steps, then return to IDLE once the last beat is accepted.
- **out_last:** high with beat len + 2*(KERNEL_SIZE-1) - 1.
- **out_data:** broadcast, so out_data[u] is identical for all u.
- **abort:** takes priority over start and any step. Next state is IDLE; out_valid, out_last and skew registers clear, and no partial beat is emitted. abort in IDLE has no effect.
- **No arithmetic:** data is never modified; zero fill is 16'h0000 (+0.0).

## Timing
- **Reset values:** busy=0, in_ready=0, out_valid=0, out_last=0, out_data all 0, state IDLE, len=0.
- **Start:** start accepted at edge T gives busy=1 and in_ready=1 from T+1 (with out_valid=0).
- **Latency:** beat j becomes valid the cycle after its step. The first beat appears the cycle after the first input handshake.
- **Throughput:** 1 beat/cycle with in_valid and out_ready held high. A full sweep takes len + 2*(KERNEL_SIZE-1) cycles from the first handshake to the last output valid.
- **Backpressure:** with out_valid && !out_ready, out_data and out_last hold stable and in_ready=0.
- **Sweep end:** busy drops the cycle after the last beat handshake. start may be accepted in that same IDLE cycle.
- **Reset mid-sweep:** all outputs go to reset values immediately (asynchronously); the next sweep requires a new start.

## Configuration
- **Macro CONV_SKEW_SAME_PAD_EN:** when defined, each sweep adds one leading and one trailing zero column (same-padding for a 3-wide kernel).
  - These columns are generated internally, not consumed from the input.
  - Sweep = len + 2 + 2*(KERNEL_SIZE-1) beats, and beat j lane i = map[i][j-i-1] when 0 <= j-i-1 < len.
  - in_ready is low during the leading pad step.
- **Without the macro:** no padding; behaviour as in Operation.

## Test plan
- **Basic sweep:** KERNEL_SIZE=3, len=6, rows {3C00,4000,3800,4200,4100,3E00}, {3800,3E00,4000,3C00,4200,3800}, {4100,3C00,4000,3E00,3800,4200}, out_ready=1 → 10 beats:
  - beat0 = {3C00,0,0}
  - beat2 = {3800,3E00,4100}
  - beat7 = {0,0,4200}
  - beats 8-9 all zero
  - out_last only on beat9
  - all SA_UNITS copies equal
- **Output backpressure:** same data, out_ready toggling 1,0,0,1 → beat sequence identical to the basic sweep; out_data stable while stalled; in_ready=0 while stalled.
- **Input gaps:** in_valid low for 2 cycles after column 3 → no beat emitted during the gap; final beat sequence unchanged.
- **Length handling:**
  - cfg_len=0 with start → busy stays 0.
  - cfg_len=MAX_LEN+5 → exactly MAX_LEN columns accepted.
- **Abort and reset:**
  - abort asserted together with a valid beat at beat 4 → next cycle out_valid=0, busy=0.
  - A following start gives a fresh sweep with beat0 lanes1-2 = 0.
  - rst_n low mid-FLUSH → all outputs 0 immediately.
- **Padding on:** with CONV_SKEW_SAME_PAD_EN, len=6 → 12 beats; beat0 = {0,0,0}, beat1 = {3C00,0,0}, beat11 is last.

Source files
------------

// File: rtl/conv_skew_feeder.sv
// conv_skew_feeder: diagonal row-skew feeder broadcasting kernel-height vectors to SA_UNITS array units.
// Define CONV_SKEW_SAME_PAD_EN to add one leading and one trailing zero column per sweep.
module conv_skew_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int SA_UNITS    = 4,
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start,
  input  logic [LEN_W-1:0]                                     cfg_len,
  input  logic                                                 abort,
  output logic                                                 busy,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]               in_col,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic                                                 out_last,
  output logic [SA_UNITS-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] out_data
);
  localparam int STEP_W = $clog2(MAX_LEN + 2*KERNEL_SIZE + 1);
`ifdef CONV_SKEW_SAME_PAD_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam logic [STEP_W-1:0] TAIL = STEP_W'(2*OFS + 2*(KERNEL_SIZE-1));

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                                  r_state;
  logic [LEN_W-1:0]                        r_len;
  logic [STEP_W-1:0]                       r_step;
  logic                                    r_out_valid;
  logic                                    r_out_last;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  r_out_vec;
  logic                                    w_adv;
  logic                                    w_need_in;
  logic                                    w_avail;
  logic                                    w_step;
  logic                                    w_start;
  logic                                    w_abort;
  logic                                    w_clr;
  logic [STEP_W-1:0]                       w_total;
  logic [STEP_W-1:0]                       w_last_step;
  logic [STEP_W-1:0]                       w_fill_end;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  w_col;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  w_lane;

  assign w_total     = STEP_W'(r_len) + TAIL;
  assign w_last_step = w_total - STEP_W'(1);
  assign w_fill_end  = STEP_W'(r_len) + STEP_W'(OFS - 1);
`ifdef CONV_SKEW_SAME_PAD_EN
  // step 0 of a padded sweep is the internal leading zero column
  assign w_need_in   = (r_state == FILL) && (r_step != '0);
`else
  assign w_need_in   = (r_state == FILL);
`endif
  assign w_abort     = abort && (r_state != IDLE);
  assign w_start     = (r_state == IDLE) && start && (cfg_len != '0);
  assign w_clr       = w_start || w_abort;
  assign w_adv       = !r_out_valid || out_ready;
  assign w_avail     = (r_state == FILL) ? (!w_need_in || in_valid) : (r_state == FLUSH) && (r_step != w_total);
  assign w_step      = w_adv && w_avail && !w_abort;
  assign w_col       = w_need_in ? in_col : '0;
  assign w_lane[0]   = w_col[0];

  for (genvar i = 1; i < KERNEL_SIZE; i++) begin : g_lane
    logic [i-1:0][DATA_WIDTH-1:0] r_sr;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sr <= '0;
      else if (w_clr) r_sr <= '0;
      else if (w_step) begin
        for (int k = i - 1; k > 0; k--) r_sr[k] <= r_sr[k-1];
        r_sr[0] <= w_col[i];
      end
    assign w_lane[i] = r_sr[i-1];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_vec   <= '0;
    end else if (w_abort) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_vec   <= '0;
    end else if (w_start) begin
      r_state     <= FILL;
      r_len       <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_vec   <= '0;
    end else begin
      if (w_step) begin
        r_out_vec   <= w_lane;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_step == w_last_step);
        r_step      <= r_step + STEP_W'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (r_state == FILL && w_step && r_step == w_fill_end) r_state <= FLUSH;
      if (r_state == FLUSH && r_out_valid && r_out_last && out_ready) r_state <= IDLE;
    end

  assign busy      = (r_state != IDLE);
  assign in_ready  = w_need_in && w_adv && !w_abort;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  for (genvar u = 0; u < SA_UNITS; u++) begin : g_bcast
    assign out_data[u] = r_out_vec;
  end
endmodule

// File: tb/tb_conv_skew_feeder.sv
// tb_conv_skew_feeder: directed sweeps with a queue scoreboard checked by an independent output monitor.
module tb_conv_skew_feeder;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int SU = 4;
  localparam int ML = 64;
  localparam int LW = $clog2(ML + 1);
`ifdef CONV_SKEW_SAME_PAD_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          start = 1'b0;
  logic [LW-1:0]                 cfg_len = '0;
  logic                          abort = 1'b0;
  logic                          busy;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [K-1:0][DW-1:0]          in_col = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic                          out_last;
  logic [SU-1:0][K-1:0][DW-1:0]  out_data;

  typedef struct packed {
    logic [K-1:0][DW-1:0] d;
    logic                 last;
  } exp_t;

  exp_t                 q[$];
  int                   n_cmp = 0;
  int                   n_err = 0;
  int                   n_beat = 0;
  int                   k_bp = 0;
  logic                 bp = 1'b0;
  logic [3:0]           pat = 4'b1001;
  logic [K-1:0][DW-1:0] hand [10];
  logic [K-1:0][DW-1:0] cols [6];

  always #5 clk = ~clk;

  conv_skew_feeder #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .SA_UNITS(SU), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_data(out_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // out_ready follows 1,0,0,1 in backpressure mode, otherwise held high
  always @(posedge clk) begin
    #1;
    out_ready = bp ? pat[k_bp % 4] : 1'b1;
    k_bp++;
  end

  always @(negedge clk) begin
    if (rst_n && !abort && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected beat: got %h expected no beat", out_data[0]);
      end else begin
        for (int u = 0; u < SU; u++)
          chk($sformatf("beat%0d unit%0d data", n_beat, u), 64'(out_data[u]), 64'(q[0].d));
        chk($sformatf("beat%0d last", n_beat), 64'(out_last), 64'(q[0].last));
        if (out_ready) begin
          void'(q.pop_front());
          n_beat++;
        end else chk("in_ready while stalled", 64'(in_ready), 64'(0));
      end
    end
  end

  function automatic logic [K-1:0][DW-1:0] colval(input int c);
    logic [K-1:0][DW-1:0] r;
    for (int i = 0; i < K; i++) r[i] = 16'(32'h1000 * (i + 1) + c);
    return r;
  endfunction

  task automatic push_hand(input int nb);
    exp_t e;
    if (OFS != 0) begin
      e.d = '0;
      e.last = 1'b0;
      q.push_back(e);
    end
    for (int j = 0; j < nb; j++) begin
      e.d = hand[j];
      e.last = (OFS == 0) && (j == 9);
      q.push_back(e);
    end
    if (OFS != 0 && nb == 10) begin
      e.d = '0;
      e.last = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic push_formula(input int len);
    exp_t e;
    int total;
    int kk;
    total = len + 2*OFS + 2*(K-1);
    for (int j = 0; j < total; j++) begin
      for (int i = 0; i < K; i++) begin
        kk = j - i - OFS;
        e.d[i] = (kk >= 0 && kk < len) ? 16'(32'h1000 * (i + 1) + kk) : 16'h0;
      end
      e.last = (j == total - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_col(input logic [K-1:0][DW-1:0] c, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_col = c;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    bit ok;
    for (int c = lo; c <= hi; c++) begin
      send_col(cols[c], ok);
      chk($sformatf("col%0d accepted", c), 64'(ok), 64'(1));
    end
  endtask

  task automatic do_start(input int len);
    cfg_len = LW'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = !busy && (q.size() == 0);
    end
    chk({nm, " completes"}, 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " in_ready"}, 64'(in_ready), 64'(0));
    chk({nm, " out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, " out_last"}, 64'(out_last), 64'(0));
    for (int u = 0; u < SU; u++) chk({nm, " out_data"}, 64'(out_data[u]), 64'(0));
  endtask

  initial begin
    bit ok;
    int cnt;
    cols[0] = {16'h4100, 16'h3800, 16'h3C00};
    cols[1] = {16'h3C00, 16'h3E00, 16'h4000};
    cols[2] = {16'h4000, 16'h4000, 16'h3800};
    cols[3] = {16'h3E00, 16'h3C00, 16'h4200};
    cols[4] = {16'h3800, 16'h4200, 16'h4100};
    cols[5] = {16'h4200, 16'h3800, 16'h3E00};
    hand[0] = {16'h0000, 16'h0000, 16'h3C00};
    hand[1] = {16'h0000, 16'h3800, 16'h4000};
    hand[2] = {16'h4100, 16'h3E00, 16'h3800};
    hand[3] = {16'h3C00, 16'h4000, 16'h4200};
    hand[4] = {16'h4000, 16'h3C00, 16'h4100};
    hand[5] = {16'h3E00, 16'h4200, 16'h3E00};
    hand[6] = {16'h3800, 16'h3800, 16'h0000};
    hand[7] = {16'h4200, 16'h0000, 16'h0000};
    hand[8] = '0;
    hand[9] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_hand(10);
    do_start(6);
    chk("start busy", 64'(busy), 64'(1));
    chk("start out_valid", 64'(out_valid), 64'(0));
    chk("start in_ready", 64'(in_ready), 64'(OFS == 0));
    send_range(0, 5);
    wait_done("basic sweep");

    bp = 1'b1;
    push_hand(10);
    do_start(6);
    send_range(0, 5);
    wait_done("backpressure sweep");
    bp = 1'b0;

    push_hand(10);
    do_start(6);
    send_range(0, 2);
    @(posedge clk);
    @(negedge clk);
    chk("gap out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    send_range(3, 5);
    wait_done("gap sweep");

    do_start(0);
    chk("len0 busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    chk("len0 busy later", 64'(busy), 64'(0));

    push_formula(ML);
    do_start(ML + 5);
    cnt = 0;
    ok = 1'b1;
    for (int c = 0; c < ML + 5 && ok; c++) begin
      send_col(colval(c), ok);
      if (ok) cnt++;
    end
    chk("max len columns accepted", 64'(cnt), 64'(ML));
    wait_done("max len sweep");

    push_hand(4);
    do_start(6);
    send_range(0, 4);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort out_valid", 64'(out_valid), 64'(0));
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort beats drained", 64'(q.size()), 64'(0));
    abort = 1'b0;
    push_hand(10);
    do_start(6);
    send_range(0, 5);
    wait_done("post-abort sweep");

    push_hand(10);
    do_start(6);
    send_range(0, 5);
    @(posedge clk);
    #1;
    chk("mid-flush busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
